// File: rtl/globals.sv
// Shared constants and types for the shift sequencer.
// Supplies the datapath width, the shift-amount width, the SHFT_* opcode codes,
// the sequencer state type and an opcode-validity helper.
package globals;

    localparam int unsigned WORDLEN = 16;
    localparam int unsigned AMTW    = $clog2(WORDLEN) + 1;

    localparam logic [2:0] SHFT_NIL = 3'd0;
    localparam logic [2:0] SHFT_SHL = 3'd1;
    localparam logic [2:0] SHFT_SHR = 3'd2;
    localparam logic [2:0] SHFT_SLA = 3'd3;
    localparam logic [2:0] SHFT_SRA = 3'd4;
    localparam logic [2:0] SHFT_ROL = 3'd5;
    localparam logic [2:0] SHFT_ROR = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } shseq_state_t;

    function automatic logic shft_valid(input logic [2:0] op);
        logic ok;
        case (op)
            SHFT_NIL, SHFT_SHL, SHFT_SHR, SHFT_SLA,
            SHFT_SRA, SHFT_ROL, SHFT_ROR: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single one-bit shift/rotate step (combinational).
// Ports:
//   op         shift opcode (SHFT_*)
//   data       word to step
//   step_carry carry produced by this step
//   step_data  stepped word
module shift_step
    import globals::*;
(
    input  logic [2:0]         op,
    input  logic [WORDLEN-1:0] data,
    output logic               step_carry,
    output logic [WORDLEN-1:0] step_data
);

    always_comb begin
        step_carry = 1'b0;
        step_data  = data;
        case (op)
            SHFT_SHL, SHFT_SLA: begin
                step_carry = data[WORDLEN-1];
                step_data  = {data[WORDLEN-2:0], 1'b0};
            end
            SHFT_SHR: begin
                step_data = {1'b0, data[WORDLEN-1:1]};
            end
            SHFT_SRA: begin
                step_data = {data[WORDLEN-1], data[WORDLEN-1:1]};
            end
            SHFT_ROL: begin
                step_carry = data[WORDLEN-1];
                step_data  = {data[WORDLEN-2:0], data[WORDLEN-1]};
            end
            SHFT_ROR: begin
                step_carry = data[0];
                step_data  = {data[0], data[WORDLEN-1:1]};
            end
            default: begin
                step_carry = 1'b0;
                step_data  = data;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: performs a shift by N (0..WORDLEN) as N
// single-bit steps, with valid/ready handshakes on request and result sides.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               request handshake
//   in_op, in_data, in_amt          opcode, operand, shift amount
//   out_valid/out_ready             result handshake
//   out_data, out_carry, out_zero   result, last-step carry, result==0
//   out_err                         opcode was undefined
module shift_sequencer
    import globals::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WORDLEN-1:0] in_data,
    input  logic [AMTW-1:0]    in_amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDLEN-1:0] out_data,
    output logic               out_carry,
    output logic               out_zero,
    output logic               out_err
);

    localparam logic [AMTW-1:0] AmtMax = AMTW'(WORDLEN);

    shseq_state_t       state_q, state_d;
    logic [AMTW-1:0]    count_q;
    logic [2:0]         op_q;
    logic [WORDLEN-1:0] data_q;
    logic               carry_q;
    logic               zero_q;
    logic               err_q;

    logic [AMTW-1:0]    amt_eff;
    logic               op_ok;
    logic               step_carry;
    logic [WORDLEN-1:0] step_data;

    assign op_ok = shft_valid(in_op);

    // Rotates wrap the amount; shifts saturate at a full word.
    always_comb begin
        amt_eff = '0;
        case (in_op)
            SHFT_ROL, SHFT_ROR:
                amt_eff = AMTW'(in_amt % AmtMax);
            SHFT_SHL, SHFT_SHR, SHFT_SLA, SHFT_SRA:
                amt_eff = (in_amt > AmtMax) ? AmtMax : in_amt;
            default:
                amt_eff = '0;
        endcase
    end

    shift_step u_step (
        .op         (op_q),
        .data       (data_q),
        .step_carry (step_carry),
        .step_data  (step_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (!op_ok || amt_eff == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_q == AMTW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= SHFT_NIL;
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        carry_q <= 1'b0;
                        if (!op_ok) begin
                            data_q  <= '0;
                            zero_q  <= 1'b1;
                            err_q   <= 1'b1;
                            count_q <= '0;
                        end else begin
                            data_q  <= in_data;
                            zero_q  <= (in_data == '0);
                            err_q   <= 1'b0;
                            count_q <= amt_eff;
                        end
                    end
                end
                RUN: begin
                    data_q  <= step_data;
                    carry_q <= step_carry;
                    zero_q  <= (step_data == '0);
                    count_q <= count_q - AMTW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_zero  = zero_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a driver pushes reference-model results,
// a negedge monitor pops and compares them whenever a result is presented.
module tb_shift_sequencer;
    import globals::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_data;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_err;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        z;
        logic        e;
        int          n;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   mode   = 2;   // out_ready: 0 random, 1 held low, 2 held high
    bit   seen   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: whole-shift arithmetic on widened words.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] d,
                                   input logic [4:0] amt);
        exp_t        r;
        int          n;
        logic [31:0] w;
        r.e = 1'b0;
        r.c = 1'b0;
        r.acc = 0;
        n = 0;
        case (op)
            SHFT_NIL: r.d = d;
            SHFT_SHL, SHFT_SLA: begin
                n = (amt > 16) ? 16 : int'(amt);
                w = {16'h0, d} << n;
                r.d = w[15:0];
                r.c = (n > 0) ? w[16] : 1'b0;
            end
            SHFT_SHR: begin
                n = (amt > 16) ? 16 : int'(amt);
                w = {d, 16'h0} >> n;
                r.d = w[31:16];
            end
            SHFT_SRA: begin
                n = (amt > 16) ? 16 : int'(amt);
                w = {{16{d[15]}}, d};
                w = $signed(w) >>> n;
                r.d = w[15:0];
            end
            SHFT_ROL: begin
                n = int'(amt) % 16;
                w = {d, d} << n;
                r.d = w[31:16];
                r.c = (n > 0) ? r.d[0] : 1'b0;
            end
            SHFT_ROR: begin
                n = int'(amt) % 16;
                w = {d, d} >> n;
                r.d = w[15:0];
                r.c = (n > 0) ? r.d[15] : 1'b0;
            end
            default: begin
                r.d = 16'h0;
                r.e = 1'b1;
            end
        endcase
        r.z = (r.d == 16'h0);
        r.n = n;
        return r;
    endfunction

    // Monitor: compares every presented result cycle, pops on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: got data %0h with no request pending", out_data);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].n));
                end
                chk("out_data", 32'(out_data), 32'(sb[0].d));
                chk("out_carry", 32'(out_carry), 32'(sb[0].c));
                chk("out_zero", 32'(out_zero), 32'(sb[0].z));
                chk("out_err", 32'(out_err), 32'(sb[0].e));
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [4:0] amt,
                        input bit push);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = amt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
        end else if (push) begin
            e = model(op, d, amt);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_data   = 16'h0;
        in_amt    = 5'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_flags", {29'd0, out_carry, out_zero, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(SHFT_SHL, 16'h8001, 5'd1, 1'b1);
        send(SHFT_ROR, 16'h0001, 5'd4, 1'b1);
        send(SHFT_ROL, 16'h8000, 5'd17, 1'b1);
        send(SHFT_SRA, 16'h8000, 5'd15, 1'b1);
        send(SHFT_SHR, 16'h00F0, 5'd20, 1'b1);
        send(SHFT_NIL, 16'h1234, 5'd7, 1'b1);
        send(3'b111, 16'hBEEF, 5'd3, 1'b1);
        send(SHFT_SHL, 16'h0001, 5'd16, 1'b1);
        send(SHFT_ROR, 16'h0001, 5'd0, 1'b1);
        drain();

        // Backpressure: result held, stray request must not be taken.
        mode = 1;
        send(SHFT_NIL, 16'h1234, 5'd7, 1'b1);
        in_valid = 1'b1;
        in_op    = SHFT_SHL;
        in_data  = 16'hFFFF;
        in_amt   = 5'd3;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h1234);
        end
        in_valid  = 1'b0;
        mode      = 2;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        send(SHFT_SLA, 16'h4001, 5'd2, 1'b1);
        drain();

        // Asynchronous reset in the middle of a run.
        send(SHFT_SHL, 16'h1234, 5'd10, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_data", 32'(out_data), 32'd0);
        chk("rst_mid_flags", {29'd0, out_carry, out_zero, out_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(SHFT_SHR, 16'h0004, 5'd2, 1'b1);
        drain();

        // Randomized traffic with random backpressure.
        mode = 0;
        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom_range(0, 31)), 1'b1);
        end
        drain();
        mode = 2;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
